// File: rtl/alu_issue_stage.sv
// alu_issue_stage: S1 operand register feeding ALU32, S2 result register for writeback.
// Define ALU_BYPASS_EN to forward the S2 result into S1 operands.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [RA_W-1:0] in_rd,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [5:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RA_W-1:0] out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_wen,
    output logic            out_illegal
);

    localparam logic [RA_W-1:0] RZERO = '0;

    logic            s1_v_q, s1_v_d;
    logic [5:0]      s1_op_q, s1_op_d;
    logic [RA_W-1:0] s1_rd_q, s1_rd_d;
    logic [XLEN-1:0] s1_a_q, s1_a_d;
    logic [XLEN-1:0] s1_b_q, s1_b_d;

    logic            s2_v_q, s2_v_d;
    logic [RA_W-1:0] s2_rd_q, s2_rd_d;
    logic [XLEN-1:0] s2_res_q, s2_res_d;
    logic            s2_wen_q, s2_wen_d;
    logic            s2_ill_q, s2_ill_d;

    logic            s2_adv, s1_adv;
    logic            in_fire, out_fire;
    logic            s1_legal;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] new_a, new_b;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        if (op[5:4] == 2'b00) begin
            case (op[3:0])
                4'h0, 4'h1, 4'h2, 4'h4, 4'h6,
                4'h8, 4'hA, 4'hB, 4'hC, 4'hE: ok = 1'b1;
                default:                      ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Handshake: S2 drains on out_ready, S1 moves when S2 frees, no bubble.
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && s2_adv;
        in_ready = !s1_v_q || s1_adv;
        in_fire  = in_valid && in_ready && !flush;
        out_fire = s2_v_q && out_ready;
    end

`ifdef ALU_BYPASS_EN
    logic [RA_W-1:0] s1_rs1_q, s1_rs1_d;
    logic [RA_W-1:0] s1_rs2_q, s1_rs2_d;
    logic            s1_imm_q, s1_imm_d;
    logic            s2_live;
    logic            fwd_a, fwd_b;
    logic            in_fwd_a, in_fwd_b;

    // Match S2 destination against held and incoming sources.
    always_comb begin
        s2_live  = s2_v_q && (s2_rd_q != RZERO);
        fwd_a    = s2_live && (s2_rd_q == s1_rs1_q);
        fwd_b    = s2_live && (s2_rd_q == s1_rs2_q) && !s1_imm_q;
        in_fwd_a = out_fire && (s2_rd_q != RZERO) && (s2_rd_q == in_rs1);
        in_fwd_b = out_fire && (s2_rd_q != RZERO) && (s2_rd_q == in_rs2)
                   && !in_use_imm;
        op_a     = fwd_a ? s2_res_q : s1_a_q;
        op_b     = fwd_b ? s2_res_q : s1_b_q;
        new_a    = in_fwd_a ? s2_res_q : in_rs1_val;
        new_b    = in_use_imm ? in_imm : (in_fwd_b ? s2_res_q : in_rs2_val);
        s1_rs1_d = s1_rs1_q;
        s1_rs2_d = s1_rs2_q;
        s1_imm_d = s1_imm_q;
        if (in_fire) begin
            s1_rs1_d = in_rs1;
            s1_rs2_d = in_rs2;
            s1_imm_d = in_use_imm;
        end
    end

    // Source indices of the op held in S1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_rs1_q <= '0;
            s1_rs2_q <= '0;
            s1_imm_q <= 1'b0;
        end else begin
            s1_rs1_q <= s1_rs1_d;
            s1_rs2_q <= s1_rs2_d;
            s1_imm_q <= s1_imm_d;
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^{in_rs1, in_rs2};

    // Operands pass unchanged; upstream interlocks on in-flight rd.
    always_comb begin
        op_a  = s1_a_q;
        op_b  = s1_b_q;
        new_a = in_rs1_val;
        new_b = in_use_imm ? in_imm : in_rs2_val;
    end
`endif

    // S1 next state: load on accept, refresh forwarded operands on writeback.
    always_comb begin
        s1_v_d  = s1_v_q;
        s1_op_d = s1_op_q;
        s1_rd_d = s1_rd_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        if (in_ready) begin
            s1_v_d = in_fire;
        end
        if (in_fire) begin
            s1_op_d = in_op;
            s1_rd_d = in_rd;
            s1_a_d  = new_a;
            s1_b_d  = new_b;
        end else if (out_fire) begin
            s1_a_d  = op_a;
            s1_b_d  = op_b;
        end
        if (flush) begin
            s1_v_d = 1'b0;
        end
    end

    // S2 next state: capture ALU result, squash it for illegal opcodes.
    always_comb begin
        s1_legal = op_legal(s1_op_q);
        s2_v_d   = s2_v_q;
        s2_rd_d  = s2_rd_q;
        s2_res_d = s2_res_q;
        s2_wen_d = s2_wen_q;
        s2_ill_d = s2_ill_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
        end
        if (s1_adv) begin
            s2_rd_d  = s1_rd_q;
            s2_res_d = s1_legal ? alu_result : '0;
            s2_wen_d = s1_legal && (s1_rd_q != RZERO);
            s2_ill_d = !s1_legal;
        end
        if (flush) begin
            s2_v_d = 1'b0;
        end
    end

    // Pipeline registers for both stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_v_q   <= 1'b0;
            s1_op_q  <= '0;
            s1_rd_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_rd_q  <= '0;
            s2_res_q <= '0;
            s2_wen_q <= 1'b0;
            s2_ill_q <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_op_q  <= s1_op_d;
            s1_rd_q  <= s1_rd_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_v_q   <= s2_v_d;
            s2_rd_q  <= s2_rd_d;
            s2_res_q <= s2_res_d;
            s2_wen_q <= s2_wen_d;
            s2_ill_q <= s2_ill_d;
        end
    end

    assign alu_a       = op_a;
    assign alu_b       = op_b;
    assign alu_opcode  = s1_op_q;
    assign out_valid   = s2_v_q;
    assign out_rd      = s2_rd_q;
    assign out_result  = s2_res_q;
    assign out_wen     = s2_wen_q;
    assign out_illegal = s2_ill_q;

endmodule
